// File: rtl/csa_pkg.sv
// csa_pkg: shared types and sizing helpers for the chunk-serial carry-save resolver.
// CSA_RESOLVE_ACC_EN widens the inter-chunk carry to cover a third (accumulator) operand.
package csa_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef CSA_RESOLVE_ACC_EN
    localparam int CW = 2;
`else
    localparam int CW = 1;
`endif

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/csa_resolve_chunk.sv
// csa_resolve_chunk: combinational CHUNK-bit slice adder with a CW-bit carry in/out.
// Under CSA_RESOLVE_ACC_EN a 3:2 row folds in the accumulator slice before the ripple add.
module csa_resolve_chunk
    import csa_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
`ifdef CSA_RESOLVE_ACC_EN
    input  logic [CHUNK-1:0] d,
`endif
    input  logic [CW-1:0]    cin,
    output logic [CHUNK-1:0] r,
    output logic [CW-1:0]    cout
);

`ifdef CSA_RESOLVE_ACC_EN
    logic [CHUNK-1:0] ps, pc;
    logic [CHUNK+1:0] t;

    // Slice total stays below 3*2^CHUNK, so the outgoing carry never exceeds 2.
    always_comb begin
        ps = a ^ b ^ d;
        pc = (a & b) | (a & d) | (b & d);
        t  = {2'b00, ps} + {1'b0, pc, 1'b0} + {{CHUNK{1'b0}}, cin};
        r    = t[CHUNK-1:0];
        cout = t[CHUNK+1:CHUNK];
    end
`else
    assign {cout, r} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
`endif

endmodule

// File: rtl/csa_resolve_seq.sv
// csa_resolve_seq: resolves a carry-save pair into binary, CHUNK bits per cycle, valid/ready on both sides.
// Optional CSA_RESOLVE_ACC_EN adds acc_clr and accumulates each result onto the previously delivered sum.
module csa_resolve_seq
    import csa_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CHUNK   = 8,
    parameter int C_SHIFT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] c,
`ifdef CSA_RESOLVE_ACC_EN
    input  logic             acc_clr,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int NCH  = nchunk(WIDTH, CHUNK);
    localparam int CNTW = NCH > 1 ? $clog2(NCH) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_cfg
            $error("csa_resolve_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state, state_nx;
    logic [CNTW-1:0]  cnt;
    logic [CW-1:0]    carry, carry_nx;
    logic [WIDTH-1:0] sr_s, sr_c;
    logic [CHUNK-1:0] chunk_sum;
    logic             spill, accept, deliver, last;

    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;
    assign last    = cnt == CNTW'(NCH - 1);

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nx = in_valid ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef CSA_RESOLVE_ACC_EN
    logic [WIDTH-1:0] sr_a, acc;

    // A same-cycle accept in DONE must see the result being handed over right now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_a <= '0;
            acc  <= '0;
        end else begin
            if (accept)
                sr_a <= acc_clr ? '0 : (deliver ? sum : acc);
            else if (state == RUN)
                sr_a <= sr_a >> CHUNK;
            if (accept && acc_clr)
                acc <= '0;
            else if (deliver)
                acc <= sum;
        end
    end
`endif

    csa_resolve_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (sr_s[CHUNK-1:0]),
        .b    (sr_c[CHUNK-1:0]),
`ifdef CSA_RESOLVE_ACC_EN
        .d    (sr_a[CHUNK-1:0]),
`endif
        .cin  (carry),
        .r    (chunk_sum),
        .cout (carry_nx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= '0;
            sr_s      <= '0;
            sr_c      <= '0;
            spill     <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                sr_s  <= s;
                sr_c  <= (C_SHIFT != 0) ? c << 1 : c;
                spill <= (C_SHIFT != 0) && c[WIDTH-1];
                carry <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                sr_s  <= sr_s >> CHUNK;
                sr_c  <= sr_c >> CHUNK;
                carry <= carry_nx;
                cnt   <= cnt + 1'b1;
                sum[int'(cnt)*CHUNK +: CHUNK] <= chunk_sum;
                if (last) carry_out <= (|carry_nx) | spill;
            end
        end
    end

endmodule

// File: tb/tb_csa_resolve_seq.sv
// tb_csa_resolve_seq: directed vector table plus handshake/reset sequences for csa_resolve_seq (WIDTH=16, CHUNK=4).
// Two instances cover C_SHIFT=0 and C_SHIFT=1; the accumulator sequence runs only with CSA_RESOLVE_ACC_EN.
module tb_csa_resolve_seq;

    typedef struct {
        logic        sh;
        logic [15:0] s;
        logic [15:0] c;
        logic [15:0] sum;
        logic        co;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        acc_clr_i = 1'b1, sel = 1'b0;
    logic [15:0] s_i = '0, c_i = '0;
    logic        ir0, ov0, co0, busy0, ir1, ov1, co1, busy1;
    logic [15:0] sum0, sum1;
    logic        ir, ov, co, busy;
    logic [15:0] sm;
    int          total = 0, bad = 0;
    int          lat;
    vec_t        tbl [9];

    assign ir   = sel ? ir1 : ir0;
    assign ov   = sel ? ov1 : ov0;
    assign co   = sel ? co1 : co0;
    assign busy = sel ? busy1 : busy0;
    assign sm   = sel ? sum1 : sum0;

    always #5 clk = ~clk;

    csa_resolve_seq #(.WIDTH(16), .CHUNK(4), .C_SHIFT(0)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(ir0),
        .s(s_i), .c(c_i),
`ifdef CSA_RESOLVE_ACC_EN
        .acc_clr(acc_clr_i),
`endif
        .out_valid(ov0), .out_ready(out_ready), .sum(sum0), .carry_out(co0), .busy(busy0)
    );

    csa_resolve_seq #(.WIDTH(16), .CHUNK(4), .C_SHIFT(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(ir1),
        .s(s_i), .c(c_i),
`ifdef CSA_RESOLVE_ACC_EN
        .acc_clr(acc_clr_i),
`endif
        .out_valid(ov1), .out_ready(out_ready), .sum(sum1), .carry_out(co1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic sh, input logic [15:0] a, input logic [15:0] b, input logic clr);
        sel = sh; s_i = a; c_i = b; acc_clr_i = clr; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!ov && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic deliver();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 16'h1234, 16'h0101, 16'h1335, 1'b0};
        tbl[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        tbl[2] = '{1'b1, 16'h0001, 16'h8000, 16'h0001, 1'b1};
        tbl[3] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1};
        tbl[4] = '{1'b0, 16'h00FF, 16'h0F01, 16'h1000, 1'b0};
        tbl[5] = '{1'b1, 16'h1111, 16'h0888, 16'h2221, 1'b0};
        tbl[6] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0001, 1'b1};
        tbl[7] = '{1'b0, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
        tbl[8] = '{1'b1, 16'h7FFF, 16'h4000, 16'hFFFF, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", ov0, 0);
        chk("rst_in_ready", ir0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_sum", sum0, 0);
        chk("rst_carry_out", co0, 0);
        chk("rst_out_valid_sh", ov1, 0);
        chk("rst_sum_sh", sum1, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            start_op(tbl[i].sh, tbl[i].s, tbl[i].c, 1'b1);
            chk($sformatf("v%0d_busy_run", i), busy, 1);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), lat, 4);
            chk($sformatf("v%0d_sum", i), sm, tbl[i].sum);
            chk($sformatf("v%0d_carry_out", i), co, tbl[i].co);
            chk($sformatf("v%0d_busy_done", i), busy, 0);
            chk($sformatf("v%0d_in_ready_done", i), ir, 0);
            deliver();
            chk($sformatf("v%0d_out_valid_after", i), ov, 0);
        end

        start_op(1'b0, 16'h1234, 16'h0101, 1'b1);
        wait_done(lat);
        chk("hold_latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_sum", i), sum0, 16'h1335);
            chk($sformatf("hold%0d_out_valid", i), ov0, 1);
            chk($sformatf("hold%0d_in_ready", i), ir0, 0);
        end
        s_i = 16'hFFFF; c_i = 16'h0001; acc_clr_i = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", ir0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_busy", busy0, 1);
        chk("b2b_out_valid", ov0, 0);
        wait_done(lat);
        chk("b2b_latency", lat, 4);
        chk("b2b_sum", sum0, 16'h0000);
        chk("b2b_carry_out", co0, 1);
        deliver();

        start_op(1'b0, 16'h1234, 16'h0101, 1'b1);
        @(posedge clk); #1;
        chk("abort_busy_before", busy0, 1);
        reset = 1'b0;
        #1;
        chk("abort_out_valid", ov0, 0);
        chk("abort_in_ready", ir0, 1);
        chk("abort_busy", busy0, 0);
        chk("abort_sum", sum0, 0);
        chk("abort_carry_out", co0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        start_op(1'b0, 16'hAAAA, 16'h5555, 1'b1);
        wait_done(lat);
        chk("post_abort_latency", lat, 4);
        chk("post_abort_sum", sum0, 16'hFFFF);
        chk("post_abort_carry_out", co0, 0);
        deliver();

`ifdef CSA_RESOLVE_ACC_EN
        start_op(1'b0, 16'h0008, 16'h0008, 1'b1);
        wait_done(lat);
        chk("acc0_sum", sum0, 16'h0010);
        deliver();
        start_op(1'b0, 16'h000F, 16'h0001, 1'b0);
        wait_done(lat);
        chk("acc1_sum", sum0, 16'h0020);
        deliver();
        start_op(1'b0, 16'h0010, 16'h0000, 1'b0);
        wait_done(lat);
        chk("acc2_sum", sum0, 16'h0030);
        deliver();
        start_op(1'b0, 16'h0003, 16'h000D, 1'b1);
        wait_done(lat);
        chk("acc3_sum", sum0, 16'h0010);
        chk("acc3_carry_out", co0, 0);
        deliver();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
